// File: rtl/cic_pkg.sv
// Shared helpers for the CIC chain: occupancy width and parameter sanity checks.
package cic_pkg;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cic_i_feeder_if.sv
// Valid/ready sample stream from the producer into the CIC input feeder.
interface cic_i_feeder_if #(
  parameter int dw = 8
);
  logic                 s_valid;
  logic signed [dw-1:0] s_data;
  logic                 s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/cic_fifo.sv
// Synchronous FIFO with occupancy count; head is the oldest entry, valid when not empty.
module cic_fifo
  import cic_pkg::*;
#(
  parameter int dw    = 8,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic signed [dw-1:0]       wdata,
  input  logic                       pop,
  output logic signed [dw-1:0]       head,
  output logic [lvl_w(depth)-1:0]    level,
  output logic                       full,
  output logic                       empty
);

  localparam int aw = $clog2(depth);
  localparam int lw = lvl_w(depth);

  if (!is_pow2(depth)) begin : g_depth_chk
    $error("cic_fifo: depth must be a power of 2 and at least 2");
  end

  logic signed [dw-1:0] mem [depth];
  logic [aw-1:0]        wr_ptr;
  logic [aw-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (level == lw'(depth));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage is not reset; only pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because depth is a power of 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cic_i_feeder.sv
// Rate-control stage ahead of the CIC interpolator: one strobe every r clocks,
// popping a buffered sample or zero-filling (and flagging) on underflow.
module cic_i_feeder
  import cic_pkg::*;
#(
  parameter int dw    = 8,
  parameter int r     = 4,
  parameter int depth = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  cic_i_feeder_if.slave           s,
  output logic                    out_dv,
  output logic signed [dw-1:0]    data_out,
  output logic                    underflow,
  output logic [lvl_w(depth)-1:0] level
);

  localparam int ph_w = (r > 1) ? $clog2(r) : 1;
  localparam logic [ph_w-1:0] ph_last = ph_w'(r - 1);

  if (r < 1) begin : g_r_chk
    $error("cic_i_feeder: r must be at least 1");
  end

  logic [ph_w-1:0]      ph;
  logic                 strobe;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic signed [dw-1:0] head;

  // NOTE: s_ready depends only on occupancy, never on s_valid, so no comb loop forms with the producer.
  assign s.s_ready = !full;
  assign push      = s.s_valid && s.s_ready;
  assign strobe    = en && (ph == '0);
  // Pop uses pre-edge emptiness, so a sample written on a strobe edge waits for the next strobe.
  assign pop       = strobe && !empty;

  cic_fifo #(
    .dw    (dw),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (s.s_data),
    .pop     (pop),
    .head    (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              ph <= '0;
    else if (!en)              ph <= '0;
    else if (ph == ph_last)    ph <= '0;
    else                       ph <= ph + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_dv    <= 1'b0;
      underflow <= 1'b0;
      data_out  <= '0;
    end else if (strobe) begin
      out_dv    <= 1'b1;
      underflow <= empty;
      data_out  <= empty ? '0 : head;
    end else begin
      out_dv    <= 1'b0;
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_i_feeder.sv
// Directed bench for cic_i_feeder (dw=8, r=4, depth=4) with immediate-assertion checks.
module tb_cic_i_feeder;

  localparam int dw    = 8;
  localparam int r     = 4;
  localparam int depth = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 en = 1'b0;
  logic                 out_dv;
  logic                 underflow;
  logic signed [dw-1:0] data_out;
  logic [2:0]           level;

  int n_cmp = 0;
  int n_bad = 0;

  cic_i_feeder_if #(.dw(dw)) s_if ();

  cic_i_feeder #(
    .dw    (dw),
    .r     (r),
    .depth (depth)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .s         (s_if.slave),
    .out_dv    (out_dv),
    .data_out  (data_out),
    .underflow (underflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic dv,
                           input logic signed [31:0] d, input logic uf);
    check({tag, ".out_dv"}, out_dv, dv);
    check({tag, ".data_out"}, data_out, d);
    check({tag, ".underflow"}, underflow, uf);
  endtask

  logic signed [dw-1:0] vec [4] = '{8'sd3, -8'sd5, 8'sd127, 8'sh80};

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;

    // Reset state
    #12;
    check_out("rst", 1'b0, 0, 1'b0);
    check("rst.level", level, 0);
    check("rst.s_ready", s_if.s_ready, 1);
    reset_n = 1'b1;
    tick();

    // Empty FIFO: zero-fill strobes every 4 cycles starting at cycle 1
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle.out_dv", out_dv, (i % 4 == 0) ? 1 : 0);
      check("idle.underflow", underflow, (i % 4 == 0) ? 1 : 0);
      check("idle.data_out", data_out, 0);
      check("idle.level", level, 0);
    end
    en = 1'b0;
    tick();
    check("en_off.out_dv", out_dv, 0);

    // Prefill 3, -5, 127, -128 then drain
    s_if.s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_if.s_data = vec[k];
      tick();
      check("fill.level", level, k + 1);
    end
    s_if.s_valid = 1'b0;
    check("fill.s_ready", s_if.s_ready, 0);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_out("drain", 1'b1, vec[k], 1'b0);
      check("drain.level", level, 3 - k);
      tick();
      check("drain.gap", out_dv, 0);
      tick();
      tick();
    end
    tick();
    check_out("drain.uf", 1'b1, 0, 1'b1);
    en = 1'b0;
    tick();

    // Continuous producer with incrementing data
    s_if.s_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      s_if.s_data = 8'(k);
      tick();
    end
    check("sat.level", level, 4);
    check("sat.s_ready", s_if.s_ready, 0);
    s_if.s_data = 8'sd5;
    en = 1'b1;
    for (int p = 0; p < 5; p++) begin
      tick();
      check_out("stream", 1'b1, p + 1, 1'b0);
      check("stream.level_pop", level, 3);
      check("stream.s_ready_pop", s_if.s_ready, 1);
      tick();
      check("stream.level_push", level, 4);
      check("stream.s_ready_full", s_if.s_ready, 0);
      check("stream.gap", out_dv, 0);
      s_if.s_data = s_if.s_data + 8'sd1;
      tick();
      tick();
    end
    s_if.s_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      tick();
      check_out("stream_tail", 1'b1, 6 + p, 1'b0);
      check("stream_tail.level", level, 3 - p);
      tick();
      tick();
      tick();
    end
    en = 1'b0;
    tick();
    check("stream_tail.empty", level, 0);

    // Push on a strobe edge into an empty FIFO: no fall-through
    en = 1'b1;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 8'sd7;
    tick();
    check_out("nofall", 1'b1, 0, 1'b1);
    check("nofall.level", level, 1);
    s_if.s_valid = 1'b0;
    tick();
    check("nofall.gap", out_dv, 0);
    tick();
    tick();
    tick();
    check_out("nofall.next", 1'b1, 7, 1'b0);
    check("nofall.level2", level, 0);
    en = 1'b0;
    tick();

    // Drop en mid-period with two samples queued
    s_if.s_valid = 1'b1;
    s_if.s_data = 8'sd11; tick();
    s_if.s_data = 8'sd22; tick();
    s_if.s_data = 8'sd33; tick();
    s_if.s_valid = 1'b0;
    check("pause.level_fill", level, 3);
    en = 1'b1;
    tick();
    check_out("pause.first", 1'b1, 11, 1'b0);
    check("pause.level_pre", level, 2);
    tick();
    check("pause.ph1", out_dv, 0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pause.out_dv", out_dv, 0);
      check("pause.level", level, 2);
    end
    check("pause.hold", data_out, 11);
    s_if.s_valid = 1'b1;
    s_if.s_data = 8'sd44; tick();
    s_if.s_data = 8'sd55; tick();
    s_if.s_valid = 1'b0;
    check("pause.level_full", level, 4);
    en = 1'b1;
    tick();
    check_out("resume", 1'b1, 22, 1'b0);
    check("resume.level", level, 3);

    // Asynchronous reset mid-period with three samples queued
    #2;
    reset_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 0, 1'b0);
    check("async_rst.level", level, 0);
    check("async_rst.s_ready", s_if.s_ready, 1);
    #1;
    reset_n = 1'b1;
    tick();
    check_out("post_rst", 1'b1, 0, 1'b1);
    check("post_rst.level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
